// File: rtl/epu_pkg.sv
// Shared EPU pipeline definitions: bubble encodings, fetch FSM states and
// instruction-cache geometry helpers.
package epu_pkg;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] NOP_INS  = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    function automatic int unsigned icache_idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Word-granular cache: the two byte-offset bits are never part of the tag.
    function automatic int unsigned icache_tag_w(input int unsigned lines);
        return 30 - $clog2(lines);
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped, one-word-per-line instruction cache with combinational hit
// compare and a single write port. Built only when ICACHE_EN is defined.
module if_icache
    import epu_pkg::*;
#(
    parameter int unsigned LINES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:2] rd_pc_i,
    output logic        hit_o,
    output logic [31:0] rd_data_o,
    input  logic        we_i,
    input  logic [31:2] wr_pc_i,
    input  logic [31:0] wr_data_i
);

    localparam int unsigned IdxW = icache_idx_w(LINES);
    localparam int unsigned TagW = icache_tag_w(LINES);

    logic [TagW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [IdxW-1:0]  rd_idx;
    logic [IdxW-1:0]  wr_idx;

    assign rd_idx    = rd_pc_i[IdxW+1:2];
    assign wr_idx    = wr_pc_i[IdxW+1:2];
    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc_i[31:IdxW+2]);
    assign rd_data_o = data_q[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx]  <= wr_pc_i[31:IdxW+2];
            data_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// EPU instruction fetch: byte-serial word assembly, stall hold, redirect with
// in-flight discard. Define ICACHE_EN to add the direct-mapped I-cache.
module if_fetch
    import epu_pkg::*;
#(
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        stall_in,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic        if_busy,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [2:0]   iss_q, iss_d;
    logic [2:0]   rcv_q, rcv_d;
    logic [31:0]  word_q, word_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ins_q, ins_d;
    logic         pend_q, pend_d;
    logic         drop_q, drop_d;

    logic         capture, complete, idle, lookup_hit, req, accept;
    logic [31:0]  full_word;
    logic         cache_hit;
    logic [31:0]  cache_data;

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_check
        $error("ICACHE_LINES must be a power of two >= 2");
    end

`ifdef ICACHE_EN
    if_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk_i     (clk_in),
        .rst_ni    (rst_in),
        .rd_pc_i   (fetch_pc_q[31:2]),
        .hit_o     (cache_hit),
        .rd_data_o (cache_data),
        .we_i      (rdy_in && !jump_flag && complete),
        .wr_pc_i   (fetch_pc_q[31:2]),
        .wr_data_i (full_word)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = ZeroWord;
`endif

    assign capture    = pend_q && !drop_q;
    assign complete   = (state_q == FETCH) && capture && (rcv_q == 3'd3);
    assign full_word  = {mem_rdata, word_q[23:0]};
    assign idle       = (state_q == FETCH) && (iss_q == 3'd0) && (rcv_q == 3'd0) && !pend_q;
    assign lookup_hit = idle && cache_hit;

    // With iss=4 the address already points at the next word, so byte 0 of
    // that word goes out in the same cycle the current word completes.
    always_comb begin
        req = 1'b0;
        if (rst_in && rdy_in && !jump_flag && state_q == FETCH) begin
            if (iss_q < 3'd4) req = !lookup_hit;
            else              req = complete && !stall_in;
        end
    end

    assign accept   = req && mem_gnt;
    assign mem_req  = req;
    assign mem_addr = fetch_pc_q + {29'd0, iss_q};
    assign if_busy  = rst_in && (state_q == FETCH) && (rcv_q < 3'd4);
    assign pc_out   = pc_q;
    assign ins_out  = ins_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        iss_d      = iss_q;
        rcv_d      = rcv_q;
        word_d     = word_q;
        pc_d       = pc_q;
        ins_d      = ins_q;
        pend_d     = accept;
        drop_d     = 1'b0;
        if (jump_flag) begin
            fetch_pc_d = jump_addr;
            iss_d      = 3'd0;
            rcv_d      = 3'd0;
            state_d    = FETCH;
            pc_d       = fetch_pc_q;
            ins_d      = NOP_INS;
            pend_d     = 1'b0;
            drop_d     = pend_q;
        end else if (state_q == WAIT) begin
            if (!stall_in) begin
                pc_d       = fetch_pc_q;
                ins_d      = word_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
                iss_d      = 3'd0;
                rcv_d      = 3'd0;
                state_d    = FETCH;
            end
        end else begin
            if (accept) iss_d = iss_q + 3'd1;
            if (capture) begin
                word_d[{rcv_q[1:0], 3'b000} +: 8] = mem_rdata;
                rcv_d = rcv_q + 3'd1;
            end
            if (complete) begin
                if (stall_in) begin
                    state_d = WAIT;
                end else begin
                    pc_d       = fetch_pc_q;
                    ins_d      = full_word;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    rcv_d      = 3'd0;
                    iss_d      = accept ? 3'd1 : 3'd0;
                end
            end else if (lookup_hit) begin
                if (!stall_in) begin
                    pc_d       = fetch_pc_q;
                    ins_d      = cache_data;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end else if (!stall_in) begin
                pc_d  = fetch_pc_q;
                ins_d = NOP_INS;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
            iss_q      <= '0;
            rcv_q      <= '0;
            word_q     <= '0;
            pc_q       <= '0;
            ins_q      <= NOP_INS;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            iss_q      <= iss_d;
            rcv_q      <= rcv_d;
            word_q     <= word_d;
            pc_q       <= pc_d;
            ins_q      <= ins_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

endmodule
